// File: rtl/sc_timer_speed_pkg.sv
// Shared types and default timing constants for the game countdown timer and
// the car-speed tick generator.
package sc_timer_speed_pkg;

  typedef enum logic [1:0] {
    STATE_IDLE   = 2'd0,
    STATE_RUN    = 2'd1,
    STATE_EXPIRE = 2'd2
  } state_t;

  localparam int DEFAULT_PRESCALE_DIV = 50_000_000;
  localparam int DEFAULT_SPEED_UNIT   = 1_250_000;

endpackage

// File: rtl/sc_timer_speed_if.sv
// Control and status signals between the game state machine and the timer block.
interface sc_timer_speed_if;
  logic       SC_TIMER_SPEED_load_InLow;
  logic [3:0] SC_TIMER_SPEED_value_In;
  logic       SC_TIMER_SPEED_clear_InLow;
  logic [3:0] SC_TIMER_SPEED_speed_In;
  logic       SC_TIMER_SPEED_timer_OutLow;
  logic       SC_TIMER_SPEED_speedComparator_OutLow;
  logic [3:0] SC_TIMER_SPEED_remaining_Out;
  logic       SC_TIMER_SPEED_busy_Out;

  modport master (
    output SC_TIMER_SPEED_load_InLow, SC_TIMER_SPEED_value_In,
           SC_TIMER_SPEED_clear_InLow, SC_TIMER_SPEED_speed_In,
    input  SC_TIMER_SPEED_timer_OutLow, SC_TIMER_SPEED_speedComparator_OutLow,
           SC_TIMER_SPEED_remaining_Out, SC_TIMER_SPEED_busy_Out
  );

  modport slave (
    input  SC_TIMER_SPEED_load_InLow, SC_TIMER_SPEED_value_In,
           SC_TIMER_SPEED_clear_InLow, SC_TIMER_SPEED_speed_In,
    output SC_TIMER_SPEED_timer_OutLow, SC_TIMER_SPEED_speedComparator_OutLow,
           SC_TIMER_SPEED_remaining_Out, SC_TIMER_SPEED_busy_Out
  );
endinterface

// File: rtl/sc_tick_divider.sv
// Free-running divider with runtime period; tick is high on the edge where the
// count wraps back to zero.
module sc_tick_divider #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] period,
  output logic             tick
);

  logic [WIDTH-1:0] count;
  logic             at_term;

  // >= rather than == so a shortened period takes effect on the next edge
  assign at_term = (count >= period - WIDTH'(1));
  assign tick    = en && !clr && at_term;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count <= '0;
    else if (clr)
      count <= '0;
    else if (en)
      count <= at_term ? '0 : count + WIDTH'(1);
  end

endmodule

// File: rtl/sc_timer_speed.sv
// Countdown timer (seconds) and move-tick generator for the car game.
// States: IDLE = waiting for load | RUN = counting down | EXPIRE = one-cycle expiry pulse
module sc_timer_speed
  import sc_timer_speed_pkg::*;
#(
  parameter int PRESCALE_DIV   = DEFAULT_PRESCALE_DIV,
  parameter int PRESCALE_WIDTH = 26,
  parameter int SPEED_UNIT     = DEFAULT_SPEED_UNIT,
  parameter int SPEED_WIDTH    = 25
) (
  input  logic              SC_TIMER_SPEED_CLOCK_50,
  input  logic              SC_TIMER_SPEED_RESET_InHigh,
  sc_timer_speed_if.slave   bus
);

  logic clk, rst;
  assign clk = SC_TIMER_SPEED_CLOCK_50;
  assign rst = SC_TIMER_SPEED_RESET_InHigh;

  logic       load_act, clear_act;
  logic [3:0] value, speed;
  assign load_act  = !bus.SC_TIMER_SPEED_load_InLow;
  assign clear_act = !bus.SC_TIMER_SPEED_clear_InLow;
  assign value     = bus.SC_TIMER_SPEED_value_In;
  assign speed     = bus.SC_TIMER_SPEED_speed_In;

  state_t     state, state_nxt;
  logic [3:0] rem, rem_nxt;
  logic       busy_q, timer_q, spd_q;
  logic       pre_tick, spd_tick;

  logic [SPEED_WIDTH-1:0] spd_period;
  assign spd_period = SPEED_WIDTH'(5'd16 - {1'b0, speed}) * SPEED_WIDTH'(SPEED_UNIT);

  sc_tick_divider #(.WIDTH(PRESCALE_WIDTH)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .en     (state == STATE_RUN),
    .clr    (load_act || clear_act),
    .period (PRESCALE_WIDTH'(PRESCALE_DIV)),
    .tick   (pre_tick)
  );

  sc_tick_divider #(.WIDTH(SPEED_WIDTH)) u_speed (
    .clk    (clk),
    .rst    (rst),
    .en     (speed != 4'd0),
    .clr    (clear_act || (speed == 4'd0)),
    .period (spd_period),
    .tick   (spd_tick)
  );

  always_comb begin
    state_nxt = state;
    rem_nxt   = rem;
    if (clear_act) begin
      state_nxt = STATE_IDLE;
      rem_nxt   = 4'd0;
    end else if (load_act) begin
      if (value != 4'd0) begin
        state_nxt = STATE_RUN;
        rem_nxt   = value;
      end else begin
        // a held zero-load alternates EXPIRE/IDLE instead of pulsing solidly
        state_nxt = (state == STATE_EXPIRE) ? STATE_IDLE : STATE_EXPIRE;
        rem_nxt   = 4'd0;
      end
    end else begin
      unique case (state)
        STATE_RUN: begin
          if (pre_tick) begin
            if (rem == 4'd1) begin
              state_nxt = STATE_EXPIRE;
              rem_nxt   = 4'd0;
            end else begin
              rem_nxt = rem - 4'd1;
            end
          end
        end
        STATE_EXPIRE: state_nxt = STATE_IDLE;
        default:      state_nxt = STATE_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= STATE_IDLE;
      rem     <= 4'd0;
      busy_q  <= 1'b0;
      timer_q <= 1'b1;
      spd_q   <= 1'b1;
    end else begin
      state   <= state_nxt;
      rem     <= rem_nxt;
      busy_q  <= (state_nxt == STATE_RUN);
      timer_q <= (state_nxt != STATE_EXPIRE);
      spd_q   <= !spd_tick;
    end
  end

  assign bus.SC_TIMER_SPEED_timer_OutLow           = timer_q;
  assign bus.SC_TIMER_SPEED_speedComparator_OutLow = spd_q;
  assign bus.SC_TIMER_SPEED_remaining_Out          = rem;
  assign bus.SC_TIMER_SPEED_busy_Out               = busy_q;

endmodule

// File: tb/tb_sc_timer_speed.sv
// Directed and randomized checks of sc_timer_speed against a start-edge based
// reference model of the countdown and a cycles-since-tick model of speed.
module tb_sc_timer_speed;
  localparam int DIV  = 4;
  localparam int UNIT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  sc_timer_speed_if ifc();

  sc_timer_speed #(
    .PRESCALE_DIV   (DIV),
    .PRESCALE_WIDTH (3),
    .SPEED_UNIT     (UNIT),
    .SPEED_WIDTH    (6)
  ) dut (
    .SC_TIMER_SPEED_CLOCK_50     (clk),
    .SC_TIMER_SPEED_RESET_InHigh (rst),
    .bus                         (ifc)
  );

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int tmr_pulses = 0, spd_pulses = 0, cur_speed = 0;

  // reference model state
  bit m_run, m_pulse, m_tick;
  int m_start, m_n, m_last_pulse, m_phase;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pulse = 0; m_tick = 0;
    m_start = 0; m_n = 0; m_last_pulse = -100; m_phase = 0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_timer"}, int'(ifc.SC_TIMER_SPEED_timer_OutLow), 1);
    chk({tag, "_spd"},   int'(ifc.SC_TIMER_SPEED_speedComparator_OutLow), 1);
    chk({tag, "_rem"},   int'(ifc.SC_TIMER_SPEED_remaining_Out), 0);
    chk({tag, "_busy"},  int'(ifc.SC_TIMER_SPEED_busy_Out), 0);
  endtask

  task automatic cycle(input bit l, input int v, input bit c, input int s);
    int exp_rem;
    ifc.SC_TIMER_SPEED_load_InLow  = l;
    ifc.SC_TIMER_SPEED_value_In    = v[3:0];
    ifc.SC_TIMER_SPEED_clear_InLow = c;
    ifc.SC_TIMER_SPEED_speed_In    = s[3:0];
    @(posedge clk);
    #1;
    cyc++;
    m_pulse = 0;
    if (!c) begin
      m_run = 0;
    end else if (!l) begin
      if (v == 0) begin
        m_run = 0;
        if (m_last_pulse != cyc - 1) m_pulse = 1;
      end else begin
        m_run = 1; m_start = cyc; m_n = v;
      end
    end else if (m_run && (cyc - m_start == m_n * DIV)) begin
      m_run = 0; m_pulse = 1;
    end
    if (m_pulse) m_last_pulse = cyc;
    exp_rem = m_run ? m_n - (cyc - m_start) / DIV : 0;

    m_tick = 0;
    if (!c || s == 0) begin
      m_phase = 0;
    end else begin
      m_phase++;
      if (m_phase >= (16 - s) * UNIT) begin
        m_tick = 1; m_phase = 0;
      end
    end

    chk("timer", int'(ifc.SC_TIMER_SPEED_timer_OutLow), m_pulse ? 0 : 1);
    chk("spd_tick", int'(ifc.SC_TIMER_SPEED_speedComparator_OutLow), m_tick ? 0 : 1);
    chk("remaining", int'(ifc.SC_TIMER_SPEED_remaining_Out), exp_rem);
    chk("busy", int'(ifc.SC_TIMER_SPEED_busy_Out), m_run ? 1 : 0);
    if (!ifc.SC_TIMER_SPEED_timer_OutLow) tmr_pulses++;
    if (!ifc.SC_TIMER_SPEED_speedComparator_OutLow) spd_pulses++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 0, 1'b1, cur_speed);
  endtask

  initial begin
    model_reset();
    ifc.SC_TIMER_SPEED_load_InLow  = 1'b1;
    ifc.SC_TIMER_SPEED_value_In    = 4'd0;
    ifc.SC_TIMER_SPEED_clear_InLow = 1'b1;
    ifc.SC_TIMER_SPEED_speed_In    = 4'd0;
    #1 rst = 1'b1;
    #1 chk_reset("por");
    #10 rst = 1'b0;
    idle(3);
    chk_reset("post_rst");

    // load 3: remaining 3/2/1, single expiry pulse at k+12
    cycle(1'b0, 3, 1'b1, cur_speed);
    chk("ld3_rem", int'(ifc.SC_TIMER_SPEED_remaining_Out), 3);
    chk("ld3_busy", int'(ifc.SC_TIMER_SPEED_busy_Out), 1);
    tmr_pulses = 0;
    for (int i = 1; i <= 13; i++) begin
      idle(1);
      if (i == 4) chk("ld3_rem_k4", int'(ifc.SC_TIMER_SPEED_remaining_Out), 2);
      if (i == 8) chk("ld3_rem_k8", int'(ifc.SC_TIMER_SPEED_remaining_Out), 1);
      if (i == 12) begin
        chk("ld3_expire", int'(ifc.SC_TIMER_SPEED_timer_OutLow), 0);
        chk("ld3_busy_k12", int'(ifc.SC_TIMER_SPEED_busy_Out), 0);
      end
    end
    chk("ld3_pulses", tmr_pulses, 1);

    // load 0 in IDLE
    tmr_pulses = 0;
    cycle(1'b0, 0, 1'b1, cur_speed);
    chk("ld0_pulse", int'(ifc.SC_TIMER_SPEED_timer_OutLow), 0);
    chk("ld0_busy", int'(ifc.SC_TIMER_SPEED_busy_Out), 0);
    idle(3);
    chk("ld0_pulses", tmr_pulses, 1);

    // reload: 2 at k, 5 at k+6, expiry at k+26 only
    cycle(1'b0, 2, 1'b1, cur_speed);
    idle(5);
    tmr_pulses = 0;
    cycle(1'b0, 5, 1'b1, cur_speed);
    chk("reload_rem", int'(ifc.SC_TIMER_SPEED_remaining_Out), 5);
    idle(19);
    chk("reload_early", tmr_pulses, 0);
    idle(1);
    chk("reload_expire", int'(ifc.SC_TIMER_SPEED_timer_OutLow), 0);

    // speed 14 / 15 / 0
    cur_speed = 14; spd_pulses = 0;
    idle(16);
    chk("spd14_pulses", spd_pulses, 4);
    idle(1);
    cur_speed = 15;
    cycle(1'b1, 0, 1'b1, cur_speed);
    chk("spd15_immediate", int'(ifc.SC_TIMER_SPEED_speedComparator_OutLow), 0);
    spd_pulses = 0;
    idle(8);
    chk("spd15_pulses", spd_pulses, 4);
    cur_speed = 0; spd_pulses = 0;
    idle(10);
    chk("spd0_pulses", spd_pulses, 0);

    // clear at k+5 during a 3 s run with speed ticking
    cur_speed = 14;
    cycle(1'b0, 3, 1'b1, cur_speed);
    idle(4);
    cycle(1'b1, 0, 1'b0, cur_speed);
    chk("clr_rem", int'(ifc.SC_TIMER_SPEED_remaining_Out), 0);
    chk("clr_busy", int'(ifc.SC_TIMER_SPEED_busy_Out), 0);
    tmr_pulses = 0; spd_pulses = 0;
    idle(3);
    chk("clr_spd_zeroed", spd_pulses, 0);
    idle(1);
    chk("clr_spd_restart", int'(ifc.SC_TIMER_SPEED_speedComparator_OutLow), 0);
    idle(16);
    chk("clr_no_expire", tmr_pulses, 0);

    // asynchronous reset mid-run
    cur_speed = 15;
    cycle(1'b0, 5, 1'b1, cur_speed);
    idle(3);
    #2 rst = 1'b1;
    #1 chk_reset("async_rst");
    @(posedge clk);
    #1 cyc++;
    chk_reset("async_rst_hold");
    rst = 1'b0;
    model_reset();
    idle(6);

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      int r;
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 39) == 0) cur_speed = int'($urandom_range(0, 15));
      cycle((r < 5) ? 1'b0 : 1'b1, (r < 2) ? 0 : int'($urandom_range(0, 6)),
            (r >= 98) ? 1'b0 : 1'b1, cur_speed);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/sc_timer_speed.md
# sc_timer_speed

Countdown timer and car-speed tick generator for the two-player car game. It is the timing responder for the general game state machine. The state machine loads a duration in seconds and waits for `timer_OutLow`. Independently, it selects a speed level and receives periodic move ticks on `speedComparator_OutLow`. One instance sits beside the state machine in the top level, clocked from the 50 MHz board clock.

## Interface
- `PRESCALE_DIV`, default 50000000: clock cycles per timer second.
- `PRESCALE_WIDTH`, default 26: prescaler counter width.
- `SPEED_UNIT`, default 1250000: cycles per speed step (25 ms).
- `SPEED_WIDTH`, default 25: speed counter width; must hold 15*`SPEED_UNIT`.
- `SC_TIMER_SPEED_CLOCK_50`, in, 1: the single clock, rising edge.
- `SC_TIMER_SPEED_RESET_InHigh`, in, 1: reset; asynchronous, active-high.
- `SC_TIMER_SPEED_load_InLow`, in, 1: low = load `value_In` and start the countdown.
- `SC_TIMER_SPEED_value_In`, in, 4: countdown length in seconds, 0..15.
- `SC_TIMER_SPEED_clear_InLow`, in, 1: low = synchronous abort of timer and speed counter.
- `SC_TIMER_SPEED_speed_In`, in, 4: speed level; 0 = no ticks.
- `SC_TIMER_SPEED_timer_OutLow`, out, 1: one-cycle low pulse on expiry.
- `SC_TIMER_SPEED_speedComparator_OutLow`, out, 1: one-cycle low pulse per move tick.
- `SC_TIMER_SPEED_remaining_Out`, out, 4: seconds remaining, for display.
- `SC_TIMER_SPEED_busy_Out`, out, 1: high while counting.

## Operation
- Timer FSM states: IDLE, RUN, EXPIRE.
  - Reset enters IDLE.
  - Priority order is clear > load > count.
- In IDLE:
  - Load with value 0 goes to EXPIRE.
  - Load with value N>0 goes to RUN, with remaining=N and prescaler=0.
- In RUN:
  - The prescaler counts 0..`PRESCALE_DIV`-1 and wraps.
  - At the prescaler terminal, remaining decrements.
  - If remaining==1 at the terminal, go to EXPIRE with remaining=0.
  - Load in RUN restarts with the new value, prescaler=0. Value 0 goes straight to EXPIRE.
  - Clear goes to IDLE with remaining=0 and prescaler=0.
- In EXPIRE:
  - `timer_OutLow`=0 and `busy_Out`=0.
  - Next state is IDLE unconditionally, unless load is low (load handled as in IDLE) or clear is low (IDLE).
- `busy_Out`=1 only in RUN.
- Speed generator:
  - Period P = (16 - speed_In) * `SPEED_UNIT`, computed at `SPEED_WIDTH` bits with no overflow.
  - The counter increments each cycle when speed_In≠0.
  - When count ≥ P-1, it pulses `speedComparator_OutLow` low for one cycle and wraps to 0.
  - The ≥ compare means a speed increase mid-period fires on the next edge rather than running to wrap-around.
  - speed_In=0 holds the counter at 0 with no pulses.
  - Clear zeroes the counter.
  - The speed generator is independent of timer state.

## Timing
- All outputs are registered.
- Reset values: `timer_OutLow`=1, `speedComparator_OutLow`=1, `remaining_Out`=0, `busy_Out`=0, both counters 0.
- Load sampled low at edge k:
  - `busy_Out`=1 and `remaining_Out`=N from k+1.
  - Decrements occur at edges k+DIV, k+2·DIV, and so on.
  - EXPIRE is entered at edge k+N·DIV, so `timer_OutLow` is low for exactly that one cycle.
  - IDLE is reached at k+N·DIV+1.
- Load of value 0 at edge k: expiry pulse in cycle k+1.
- Load held low continuously restarts every cycle, so no expiry occurs, except value 0, which pulses every other cycle.
- Speed tick: the first pulse is P cycles after speed becomes nonzero from a zero counter; pulses then repeat every P cycles.
- Asynchronous reset mid-run forces all reset values immediately, with no pulse emitted.

## Structure
- Package `sc_timer_speed_pkg` holds:
  - the state encodings STATE_IDLE=0, STATE_RUN=1, STATE_EXPIRE=2 (2-bit);
  - default PRESCALE_DIV and SPEED_UNIT constants shared with the top level.
- Sub-module `sc_tick_divider`: parameterised width, runtime period input, enable, sync clear, one-cycle tick output.
  - It is instantiated twice: as the prescaler (period `PRESCALE_DIV`, enabled in RUN) and as the speed generator (period P).

## Test plan
Bench parameters: `PRESCALE_DIV`=4, `SPEED_UNIT`=2.
- **Reset:** assert reset asynchronously mid-cycle → outputs 1/1/0/0 immediately; hold after release with inputs idle.
- **Load 3 at edge k:**
  - `remaining_Out` reads 3, 2, 1 from k+1, k+4, k+8.
  - `timer_OutLow` is low only in cycle k+12.
  - `busy_Out` is 0 from k+12; a single pulse only.
- **Load 0 in IDLE:** one low pulse on `timer_OutLow` in cycle k+1; `busy_Out` stays 0.
- **Reload:** load 2 at k, then load 5 at k+6 → remaining=5 at k+7, expiry pulse at k+26, no pulse at k+8.
- **Speed:**
  - speed 14 → ticks every 4 cycles;
  - switch to 15 → ticks every 2 cycles, first one on the next edge if count ≥ 1;
  - speed 0 → no ticks.
- **Clear:** clear low at k+5 during a 3-second run → IDLE, remaining=0, no expiry pulse, speed counter zeroed.
